// File: rtl/switch_pkg.sv
// Shared switch definitions: arbiter state encoding and metadata field layout.
package switch_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_START,
    ARB_BUSY
  } arb_state_e;

  localparam int unsigned META_W        = 32;
  localparam int unsigned META_DEST_LSB = 0;
  localparam int unsigned META_DEST_MSB = 1;

  typedef struct packed {
    logic [META_W-3:0] user;
    logic [1:0]        dest;
  } meta_t;

  function automatic logic [1:0] meta_dest(input logic [META_W-1:0] meta);
    return meta[META_DEST_MSB:META_DEST_LSB];
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set bit of eligible searching upward from rr_ptr, wrapping.
module rr_select #(
  parameter  int unsigned N_IN = 4,
  localparam int unsigned PW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic [N_IN-1:0] eligible,
  input  logic [PW-1:0]   rr_ptr,
  output logic            valid,
  output logic [PW-1:0]   index
);

  int unsigned cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int unsigned off = 0; off < N_IN; off++) begin
      cand = 32'(rr_ptr) + off;
      if (cand >= N_IN) cand = cand - N_IN;
      if (!valid && eligible[cand]) begin
        valid = 1'b1;
        index = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port arbiter: round-robin grant of eligible input queues, start/ready
// handshake with the port controller, and a combinational stream mux for the grant.
module output_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned N_IN          = 4,
  parameter logic [1:0]  PORT_ID       = 2'd0,
  parameter int unsigned GRANT_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_IN-1:0]        in_buf_tvalid,
  input  logic [N_IN-1:0]        in_buf_tlast,
  input  logic [8*N_IN-1:0]      in_buf_tdata,
  output logic [N_IN-1:0]        in_buf_tready,
  input  logic [N_IN-1:0]        in_meta_tvalid,
  input  logic [META_W*N_IN-1:0] in_meta_tdata,
  output logic [N_IN-1:0]        in_meta_tready,
  output logic                   buf_axis_tvalid,
  output logic                   buf_axis_tlast,
  output logic [7:0]             buf_axis_tdata,
  input  logic                   buf_axis_tready,
  output logic                   meta_axis_tvalid,
  output logic [META_W-1:0]      meta_axis_tdata,
  input  logic                   meta_axis_tready,
  output logic                   start_transfer,
  input  logic                   ready_transfer,
  output logic [N_IN-1:0]        grant_onehot,
  output logic                   timeout_err
);

  localparam int unsigned PW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned TW = $clog2(GRANT_TIMEOUT + 1);

  arb_state_e        state_q;
  logic              grant_valid_q;
  logic [PW-1:0]     grant_idx_q;
  logic [PW-1:0]     rr_ptr_q;
  logic [PW-1:0]     rr_ptr_d;
  logic              start_q;
  logic              timeout_q;
  logic [TW-1:0]     tmo_cnt_q;
  logic [N_IN-1:0]   eligible;
  logic              win_valid;
  logic [PW-1:0]     win_idx;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      eligible[i] = in_meta_tvalid[i] & in_buf_tvalid[i]
                  & (meta_dest(in_meta_tdata[META_W*i +: META_W]) == PORT_ID);
    end
  end

  rr_select #(.N_IN(N_IN)) u_rr_select (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .valid    (win_valid),
    .index    (win_idx)
  );

  assign rr_ptr_d = (grant_idx_q == PW'(N_IN - 1)) ? '0 : grant_idx_q + PW'(1);

  // Grant is cleared on the BUSY exit edge, so it stays valid during the cycle in
  // which ready_transfer is sampled high and the metadata handshake completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ARB_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      start_q       <= 1'b0;
      timeout_q     <= 1'b0;
      tmo_cnt_q     <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (ready_transfer && win_valid) begin
            grant_valid_q <= 1'b1;
            grant_idx_q   <= win_idx;
            start_q       <= 1'b1;
            tmo_cnt_q     <= '0;
            state_q       <= ARB_START;
          end
        end
        ARB_START: begin
          if (!ready_transfer) begin
            start_q <= 1'b0;
            state_q <= ARB_BUSY;
          end else if (tmo_cnt_q == TW'(GRANT_TIMEOUT - 1)) begin
            start_q       <= 1'b0;
            timeout_q     <= 1'b1;
            grant_valid_q <= 1'b0;
            state_q       <= ARB_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
          end
        end
        ARB_BUSY: begin
          if (ready_transfer) begin
            grant_valid_q <= 1'b0;
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_axis_tvalid  = 1'b0;
    buf_axis_tlast   = 1'b0;
    buf_axis_tdata   = '0;
    meta_axis_tvalid = 1'b0;
    meta_axis_tdata  = '0;
    in_buf_tready    = '0;
    in_meta_tready   = '0;
    grant_onehot     = '0;
    if (grant_valid_q) begin
      grant_onehot[grant_idx_q]   = 1'b1;
      buf_axis_tvalid             = in_buf_tvalid[grant_idx_q];
      buf_axis_tlast              = in_buf_tlast[grant_idx_q];
      buf_axis_tdata              = in_buf_tdata[8*grant_idx_q +: 8];
      meta_axis_tvalid            = in_meta_tvalid[grant_idx_q];
      meta_axis_tdata             = in_meta_tdata[META_W*grant_idx_q +: META_W];
      in_buf_tready[grant_idx_q]  = buf_axis_tready;
      in_meta_tready[grant_idx_q] = meta_axis_tready;
    end
  end

  assign start_transfer = start_q;
  assign timeout_err    = timeout_q;

endmodule
